// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined signed/unsigned multiplier built from Urdhva-Tiryagbhyam
// 2x2 cells; S1 takes magnitudes, S2 forms four half-width products, S3 combines and signs.
module vedic_mult_pipe #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The whole pipe freezes when the output holds a product the consumer refuses.
    localparam int H = WIDTH / 2;

    function automatic logic [3:0] cell2(input logic [1:0] a, input logic [1:0] b);
        logic c1;
        logic [3:0] y;
        c1   = a[1] & b[0] & a[0] & b[1];
        y[0] = a[0] & b[0];
        y[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        y[2] = (a[1] & b[1]) ^ c1;
        y[3] = a[1] & b[1] & c1;
        return y;
    endfunction

    // The recursive split flattens to a grid of 2x2 cells, each weighted by its digit position.
    function automatic logic [WIDTH-1:0] vedic_half(input logic [H-1:0] a, input logic [H-1:0] b);
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < H / 2; i++) begin
            for (int j = 0; j < H / 2; j++) begin
                acc = acc + (WIDTH'(cell2(a[2*i +: 2], b[2*j +: 2])) << (2 * (i + j)));
            end
        end
        return acc;
    endfunction

    logic               stall;
    logic               sgn;

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s1_mag_p_q, s1_mag_p_d;
    logic [WIDTH-1:0]   s1_mag_q_q, s1_mag_q_d;
    logic               s1_neg_q, s1_neg_d;

    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   s2_ll_q, s2_ll_d;
    logic [WIDTH-1:0]   s2_lh_q, s2_lh_d;
    logic [WIDTH-1:0]   s2_hl_q, s2_hl_d;
    logic [WIDTH-1:0]   s2_hh_q, s2_hh_d;
    logic               s2_neg_q, s2_neg_d;

    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic [2*WIDTH-1:0] mag_sum;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign sgn       = in_signed & SIGNED_EN;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    assign mag_sum = {{WIDTH{1'b0}}, s2_ll_q}
                   + {{H{1'b0}}, s2_lh_q, {H{1'b0}}}
                   + {{H{1'b0}}, s2_hl_q, {H{1'b0}}}
                   + {s2_hh_q, {WIDTH{1'b0}}};

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mag_p_d  = s1_mag_p_q;
        s1_mag_q_d  = s1_mag_q_q;
        s1_neg_d    = s1_neg_q;
        s2_valid_d  = s2_valid_q;
        s2_ll_d     = s2_ll_q;
        s2_lh_d     = s2_lh_q;
        s2_hl_d     = s2_hl_q;
        s2_hh_d     = s2_hh_q;
        s2_neg_d    = s2_neg_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (!stall) begin
            s1_valid_d  = in_valid;
            s1_mag_p_d  = (sgn && p[WIDTH-1]) ? -p : p;
            s1_mag_q_d  = (sgn && q[WIDTH-1]) ? -q : q;
            s1_neg_d    = sgn & (p[WIDTH-1] ^ q[WIDTH-1]);
            s2_valid_d  = s1_valid_q;
            s2_ll_d     = vedic_half(s1_mag_p_q[H-1:0],     s1_mag_q_q[H-1:0]);
            s2_lh_d     = vedic_half(s1_mag_p_q[H-1:0],     s1_mag_q_q[WIDTH-1:H]);
            s2_hl_d     = vedic_half(s1_mag_p_q[WIDTH-1:H], s1_mag_q_q[H-1:0]);
            s2_hh_d     = vedic_half(s1_mag_p_q[WIDTH-1:H], s1_mag_q_q[WIDTH-1:H]);
            s2_neg_d    = s1_neg_q;
            out_valid_d = s2_valid_q;
            // A zero magnitude negates to zero, so no negative zero can emerge.
            out_d       = s2_neg_q ? -mag_sum : mag_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mag_p_q  <= '0;
            s1_mag_q_q  <= '0;
            s1_neg_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_ll_q     <= '0;
            s2_lh_q     <= '0;
            s2_hl_q     <= '0;
            s2_hh_q     <= '0;
            s2_neg_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mag_p_q  <= s1_mag_p_d;
            s1_mag_q_q  <= s1_mag_q_d;
            s1_neg_q    <= s1_neg_d;
            s2_valid_q  <= s2_valid_d;
            s2_ll_q     <= s2_ll_d;
            s2_lh_q     <= s2_lh_d;
            s2_hl_q     <= s2_hl_d;
            s2_hh_q     <= s2_hh_d;
            s2_neg_q    <= s2_neg_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: doc/vedic_mult_pipe.md
VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width; legal values are 4, 8, 16 and 32.
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; when 1 the per-transaction signed mode is honoured, when 0 in_signed is ignored and treated as 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair this cycle.
REQ-007 The block SHALL have port p, input, WIDTH bits: multiplicand.
REQ-008 The block SHALL have port q, input, WIDTH bits: multiplier.
REQ-009 The block SHALL have port in_signed, input, 1 bit: 1 treats p and q as two's complement, 0 treats them as unsigned.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the product is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-012 The block SHALL have port out, output, 2*WIDTH bits: the product.

Function
REQ-013 An input transfer SHALL occur on a rising clk edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-014 The pipeline SHALL have exactly 3 register stages:
- S1: capture the operands and the sign mode, and convert each operand to its magnitude.
- S2: form the four WIDTH/2 partial products by recursive Vedic (Urdhva-Tiryagbhyam) decomposition down to 2x2 cells.
- S3: perform the cross-term addition and the final sign correction.
REQ-015 With no stall, out_valid SHALL assert exactly 3 cycles after the input-transfer edge, and each transaction SHALL carry its own in_signed value.
REQ-016 A global stall SHALL be defined as stall = out_valid AND NOT out_ready.
- While stall is 1, every stage SHALL hold its contents and in_ready SHALL be 0.
- While stall is 0, in_ready SHALL be 1.
REQ-017 in_ready SHALL depend combinationally only on out_valid and out_ready.
REQ-018 Back-to-back input transfers SHALL be accepted every cycle while out_ready is 1, giving a throughput of one product per clk.
REQ-019 Stage valid bits SHALL propagate unchanged through pipeline bubbles, and a bubble SHALL never assert out_valid.
REQ-020 Unsigned mode SHALL produce out = p*q modulo 2^(2*WIDTH); this is exact, because the maximum product (2^WIDTH-1)^2 fits in 2*WIDTH bits.
REQ-021 Signed mode SHALL work as follows:
- Take the magnitudes |p| and |q|, each WIDTH bits, with -2^(WIDTH-1) mapping to 2^(WIDTH-1).
- Multiply the magnitudes unsigned.
- Negate the product (two's complement, 2*WIDTH bits) when p[WIDTH-1] XOR q[WIDTH-1] is 1.
REQ-022 A zero operand in signed mode SHALL produce out = 0; no negative zero exists.
REQ-023 The internal adders SHALL be carry-complete, so no carry is dropped at any cross-term addition.
REQ-024 The block SHALL have no combinational path from p, q or in_signed to out.
REQ-025 out and out_valid SHALL be driven directly from S3 registers.
REQ-026 out SHALL hold a stable value while out_valid is 1 and out_ready is 0.

Reset
REQ-027 While rst is 1 at a rising edge, all stage valid bits SHALL clear to 0, out_valid SHALL be 0 and out SHALL be 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts, provided out_ready is at any value; this holds because out_valid is 0.
REQ-029 Reset asserted mid-operation SHALL discard every in-flight transaction, and no discarded product SHALL appear after reset.
REQ-030 Reset SHALL take priority over a simultaneous input transfer or output transfer.

Verification
REQ-031 WIDTH=4, unsigned: p=15, q=15, out_ready=1 -> out=225 (0xE1), with out_valid=1 exactly 3 cycles after the input transfer.
REQ-032 WIDTH=8, signed: p=0x80 (-128), q=0x80 -> out=0x4000; then p=0x80, q=0x01 -> out=0xFF80; then p=0x00, q=0xFF -> out=0.
REQ-033 WIDTH=8, 5 consecutive transfers with out_ready=1 and alternating in_signed (p=0xFF, q=0x02) -> outputs on 5 consecutive cycles of 0x01FE, 0xFFFE, 0x01FE, 0xFFFE, 0x01FE.
REQ-034 Backpressure: out_ready=0 for 4 cycles while in_valid is held at 1 -> in_ready=0 during the stall and out stays stable.
- No transaction may be lost or duplicated.
- Order is preserved after out_ready rises.
REQ-035 Assert rst for 1 cycle while 3 transactions are in flight -> out_valid=0 on the following cycle, and none of the 3 products ever appears.
REQ-036 Random regression for each legal WIDTH, with random in_valid and out_ready -> every product matches a scoreboard computing p*q with the sign mode applied, in order, with zero mismatches.
